// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, registers one word into a single-entry IR with valid/ready toward decode.
// Handles jump/branch redirects (one bubble) and a HALT_WORD-triggered halt that is left by a resume pulse.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        de_ready,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [15:0] target,
  input  logic        resume,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic [15:0] count_q, count_d;

  logic transfer;
  logic redirect;
  logic slot_free;

  assign transfer  = ir_valid_q && de_ready;
  assign redirect  = transfer && (jump || branch_taken);
  assign slot_free = !ir_valid_q || de_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      ir_valid_q <= 1'b0;
      count_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    count_d    = count_q;

    if (transfer && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end

    unique case (state_q)
      S_RUN: begin
        // A redirect discards the wrong-path word on imem_data, even a halt word.
        if (redirect) begin
          pc_d       = target;
          ir_valid_d = 1'b0;
        end else if (slot_free && (imem_data == HALT_WORD)) begin
          ir_valid_d = 1'b0;
          state_d    = S_HALTED;
        end else if (slot_free) begin
          ir_d       = imem_data;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + 16'd1;
        end
      end
      S_HALTED: begin
        ir_valid_d = 1'b0;
        if (resume) begin
          pc_d    = pc_q + 16'd1;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  assign imem_addr   = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = (state_q == S_HALTED);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected delivered addresses, a negedge monitor pops on every transfer.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] ir, ir_pc, fetch_count;
  logic        ir_valid, halted;
  logic        de_ready = 1'b0, jump = 1'b0, branch_taken = 1'b0, resume = 1'b0;
  logic [15:0] target = 16'h0000;

  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0000;

  logic        rst_n_w = 1'b0;
  logic [15:0] imem_addr_w, imem_data_w, ir_w, ir_pc_w, fetch_count_w;
  logic        ir_valid_w, halted_w;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  // Instruction memory model: address-derived words, with one optional halt word.
  assign imem_data   = (halt_en && imem_addr == halt_addr) ? 16'hFFFF : (imem_addr ^ 16'h5A00);
  assign imem_data_w = imem_addr_w ^ 16'h5A00;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .de_ready(de_ready),
    .jump(jump), .branch_taken(branch_taken), .target(target), .resume(resume),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .ir(ir_w), .ir_pc(ir_pc_w), .ir_valid(ir_valid_w), .de_ready(1'b1),
    .jump(1'b0), .branch_taken(1'b0), .target(16'h0000), .resume(1'b0),
    .halted(halted_w), .fetch_count(fetch_count_w)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ir_valid && de_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_transfer", ir_pc, 16'hxxxx);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("sb_ir_pc", ir_pc, e);
        check("sb_ir", ir, e ^ 16'h5A00);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [15:0] lo, input logic [15:0] hi);
    for (int a = lo; a <= hi; a++) exp_q.push_back(16'(a));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      de_ready = 1'($urandom); jump = 1'($urandom); branch_taken = 1'($urandom);
      resume = 1'($urandom); target = 16'($urandom);
      tick();
    end
    check("rst_imem_addr", imem_addr, 16'h0000);
    check("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_fetch_count", fetch_count, 16'd0);
    de_ready = 1'b1; jump = 1'b0; branch_taken = 1'b0; resume = 1'b0; target = 16'h0000;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_pc(input logic [15:0] pc, input int max);
    int n = 0;
    while (!(ir_valid && ir_pc == pc) && n < max) begin
      tick();
      n++;
    end
    check("wait_pc", {15'd0, (ir_valid && ir_pc == pc)}, 16'd1);
  endtask

  task automatic drain_check();
    tick();
    tick();
    check("sb_drained", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    // Reset, streaming, resume-in-RUN ignored, backpressure with stray jump.
    do_reset();
    push_range(16'd0, 16'd6);
    for (int i = 0; i < 4; i++) begin
      resume = (i == 1);
      tick();
      check("stream_valid", {15'd0, ir_valid}, 16'd1);
      check("stream_ir_pc", ir_pc, 16'(i));
    end
    resume = 1'b0;
    wait_pc(16'd5, 10);
    de_ready = 1'b0; jump = 1'b1; target = 16'h0077;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ir_pc", ir_pc, 16'd5);
      check("bp_ir", ir, 16'h5A05);
      check("bp_imem_addr", imem_addr, 16'd6);
      check("bp_fetch_count", fetch_count, 16'd5);
    end
    jump = 1'b0;
    de_ready = 1'b1;
    tick();
    check("bp_release_pc", ir_pc, 16'd6);
    tick();
    check("bp_next_pc", ir_pc, 16'd7);
    de_ready = 1'b0;
    drain_check();

    // Jump from address 4 to 0x0040.
    do_reset();
    push_range(16'd0, 16'd4);
    exp_q.push_back(16'h0040);
    wait_pc(16'd4, 10);
    jump = 1'b1; target = 16'h0040;
    tick();
    jump = 1'b0; target = 16'h1234;
    check("jmp_bubble", {15'd0, ir_valid}, 16'd0);
    check("jmp_imem_addr", imem_addr, 16'h0040);
    tick();
    check("jmp_tgt_valid", {15'd0, ir_valid}, 16'd1);
    check("jmp_tgt_pc", ir_pc, 16'h0040);
    tick();
    de_ready = 1'b0;
    drain_check();

    // Halt at address 3, then resume.
    halt_en = 1'b1; halt_addr = 16'd3;
    do_reset();
    push_range(16'd0, 16'd2);
    exp_q.push_back(16'd4);
    for (int n = 0; n < 10 && !halted; n++) tick();
    check("halt_halted", {15'd0, halted}, 16'd1);
    check("halt_ir_valid", {15'd0, ir_valid}, 16'd0);
    check("halt_imem_addr", imem_addr, 16'd3);
    check("halt_fetch_count", fetch_count, 16'd3);
    tick();
    tick();
    check("halt_hold", {15'd0, halted}, 16'd1);
    check("halt_hold_addr", imem_addr, 16'd3);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_halted", {15'd0, halted}, 16'd0);
    check("resume_bubble", {15'd0, ir_valid}, 16'd0);
    check("resume_addr", imem_addr, 16'd4);
    tick();
    check("resume_valid", {15'd0, ir_valid}, 16'd1);
    check("resume_pc", ir_pc, 16'd4);
    tick();
    de_ready = 1'b0;
    drain_check();

    // Taken branch with a halt word on the wrong path.
    halt_addr = 16'd9;
    do_reset();
    push_range(16'd0, 16'd8);
    wait_pc(16'd8, 15);
    branch_taken = 1'b1; target = 16'h0020;
    tick();
    branch_taken = 1'b0;
    check("wp_halted", {15'd0, halted}, 16'd0);
    check("wp_bubble", {15'd0, ir_valid}, 16'd0);
    check("wp_imem_addr", imem_addr, 16'h0020);
    de_ready = 1'b0;
    tick();
    check("wp_tgt_valid", {15'd0, ir_valid}, 16'd1);
    check("wp_tgt_pc", ir_pc, 16'h0020);
    check("wp_halted2", {15'd0, halted}, 16'd0);
    drain_check();
    halt_en = 1'b0;

    // Asynchronous reset during a redirect bubble.
    do_reset();
    push_range(16'd0, 16'd2);
    wait_pc(16'd2, 10);
    jump = 1'b1; target = 16'h0030;
    tick();
    jump = 1'b0;
    check("ar_bubble", {15'd0, ir_valid}, 16'd0);
    check("ar_pre_addr", imem_addr, 16'h0030);
    rst_n = 1'b0;
    #1;
    check("ar_imem_addr", imem_addr, 16'h0000);
    check("ar_ir", ir, 16'h0000);
    check("ar_ir_pc", ir_pc, 16'h0000);
    check("ar_ir_valid", {15'd0, ir_valid}, 16'd0);
    check("ar_halted", {15'd0, halted}, 16'd0);
    check("ar_fetch_count", fetch_count, 16'd0);
    check("ar_sb_drained", 16'(exp_q.size()), 16'd0);

    // PC wrap from a non-zero reset address.
    tick();
    check("wrap_rst_addr", imem_addr_w, 16'hFFFE);
    rst_n_w = 1'b1;
    tick();
    check("wrap_pc0", ir_pc_w, 16'hFFFE);
    tick();
    check("wrap_pc1", ir_pc_w, 16'hFFFF);
    tick();
    check("wrap_pc2", ir_pc_w, 16'h0000);
    check("wrap_ir2", ir_w, 16'h5A00);
    check("wrap_valid", {15'd0, ir_valid_w}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of decode/execute in the 16-bit CPU. It owns the program counter and drives the combinational instruction memory address. It registers each fetched word into a single-entry instruction register (IR) with a valid/ready handshake toward decode. It also handles jump/branch redirects and a halt/resume state machine.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetching

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  16  instruction memory address, equal to the PC register (combinational from the register)
- imem_data  in  16  instruction word returned combinationally by imem for imem_addr
- ir  out  16  registered instruction presented to decode
- ir_pc  out  16  address that `ir` was fetched from
- ir_valid  out  1  `ir`/`ir_pc` hold a deliverable instruction
- de_ready  in  1  decode accepts `ir` this cycle; a transfer is ir_valid && de_ready
- jump  in  1  consumed instruction is a jump; valid only during a transfer
- branch_taken  in  1  consumed instruction is a taken branch; valid only during a transfer
- target  in  16  redirect address for jump/branch_taken
- resume  in  1  single-cycle pulse to leave HALTED
- halted  out  1  high while in HALTED
- fetch_count  out  16  number of completed transfers, saturating at 16'hFFFF

## Operation
- States:
  - RUN: fetching.
  - HALTED: no fetching.
- Reset state is RUN.
- Slot free this cycle: !ir_valid || de_ready.
- redirect = ir_valid && de_ready && (jump || branch_taken). jump/branch_taken are ignored when not part of a transfer.
- RUN, per cycle, first matching rule wins:
  - redirect: pc <= target, ir_valid <= 0. The word on imem_data is wrong-path and is discarded, including a HALT_WORD.
  - Slot free and imem_data == HALT_WORD: ir_valid <= 0, pc holds (points at the halt word), state <= HALTED.
  - Slot free: ir <= imem_data, ir_pc <= pc, ir_valid <= 1, pc <= pc + 1 (mod 2^16; 16'hFFFF wraps to 16'h0000).
  - Otherwise (backpressure): pc, ir, ir_pc, ir_valid hold.
- HALTED:
  - ir_valid is always 0, so no transfers and no redirects occur.
  - pc holds.
  - resume: pc <= pc + 1 (skips the halt word), state <= RUN; fetch resumes the next cycle.
  - resume in RUN is ignored.
- fetch_count increments by 1 on each transfer and holds at 16'hFFFF once reached.
- HALT_WORD is never presented on `ir`.

## Timing
- Reset (async assert, any cycle, including mid-redirect or HALTED):
  - pc = RESET_PC, ir = 16'h0000, ir_pc = 16'h0000, ir_valid = 0, halted = 0, fetch_count = 0, state RUN.
  - First edge after deassertion captures the word at RESET_PC.
- Fetch latency: the instruction at address A is on `ir` one cycle after pc == A with the slot free.
- Throughput: one instruction per cycle while de_ready is held high.
- Redirect penalty: exactly one bubble cycle (ir_valid = 0). The target instruction is valid two edges after the redirecting transfer.
- Halt: `halted` rises on the edge that sees HALT_WORD with the slot free. After resume, `halted` falls on the next edge; the first post-halt instruction is valid one edge later.
- ir, ir_pc, ir_valid, halted, fetch_count are all registered outputs; imem_addr is combinational from pc only.

## Test plan
- Reset: hold rst_n = 0 with random inputs -> imem_addr = 16'h0000, ir_valid = 0, halted = 0, fetch_count = 0. Release -> ir_pc = 0, 1, 2, 3 on successive cycles with de_ready = 1.
- Backpressure: de_ready = 0 for 3 cycles while ir_pc = 5 -> ir, ir_pc, imem_addr = 6 all frozen, fetch_count unchanged. Raise de_ready -> ir_pc = 6 next cycle, no instruction lost or duplicated.
- Jump: transfer of ir_pc = 4 with jump = 1, target = 16'h0040 -> one bubble, then ir_pc = 16'h0040. The word at address 5 is never delivered.
- Halt/resume: imem[3] = 16'hFFFF -> ir_pc 0..2 delivered, halted = 1, imem_addr stays 3, fetch_count = 3. Pulse resume -> ir_pc = 4 valid two edges later.
- Wrong-path halt: imem[9] = 16'hFFFF, transfer of ir_pc = 8 with branch_taken = 1, target = 16'h0020 -> halted stays 0, next valid ir_pc = 16'h0020.
- Wrap and mid-operation reset: RESET_PC = 16'hFFFE -> ir_pc = FFFE, FFFF, 0000. Assert rst_n low during a redirect bubble -> all outputs return to reset values immediately (asynchronously).
